// File: rtl/cen_gen_if.sv
// Configuration and enable-output bundle for the clock-enable generator.
// The master side belongs to the controller/bench; the slave side belongs to cen_gen.
interface cen_gen_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                pause;
  logic                sync;
  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_W-1:0]    cfg_num;
  logic [ACC_W-1:0]    cfg_den;
  logic [CHANNELS-1:0] cen;
  logic                cfg_err;

  modport master (
    output pause, sync, cfg_wr, cfg_ch, cfg_num, cfg_den,
    input  cen, cfg_err
  );

  modport slave (
    input  pause, sync, cfg_wr, cfg_ch, cfg_num, cfg_den,
    output cen, cfg_err
  );
endinterface

// File: rtl/cen_gen.sv
// Multi-channel rational clock-enable generator.
// Each channel accumulates min(num, den) per cycle and emits a one-cycle
// enable whenever the accumulator wraps past den, giving a rate of n/den.
module cen_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16,
  parameter int DEF_NUM  = 1,
  parameter int DEF_DEN  = 2
) (
  input  logic     clk_sys,
  input  logic     reset,
  cen_gen_if.slave bus
);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CH_SPAN = 1 << CH_W;
  // One bit per encodable channel index; set only for indices that exist.
  localparam logic [CH_SPAN-1:0] CH_VALID = {CH_SPAN{1'b1}} >> (CH_SPAN - CHANNELS);

  logic [CHANNELS-1:0][ACC_W-1:0] num_q, den_q, acc_q, acc_d, n_eff;
  logic [CHANNELS-1:0][ACC_W:0]   sum;
  logic [CHANNELS-1:0]            cen_q, cen_d, wr_sel;
  logic                           cfg_err_q, ch_ok, wr_ok;

  assign ch_ok  = CH_VALID[bus.cfg_ch];
  assign wr_ok  = bus.cfg_wr && ch_ok;
  assign wr_sel = wr_ok ? (CHANNELS'(1) << bus.cfg_ch) : '0;

  // Per-channel phase step; the sum keeps the carry bit so num near 2^ACC_W cannot wrap.
  always_comb begin
    acc_d = acc_q;
    cen_d = '0;
    n_eff = '0;
    sum   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n_eff[i] = (num_q[i] < den_q[i]) ? num_q[i] : den_q[i];
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, n_eff[i]};
      if (bus.sync || wr_sel[i]) begin
        acc_d[i] = '0;
      end else if (!bus.pause && (num_q[i] != '0) && (den_q[i] != '0)) begin
        if (sum[i] >= {1'b0, den_q[i]}) begin
          acc_d[i] = ACC_W'(sum[i] - {1'b0, den_q[i]});
          cen_d[i] = 1'b1;
        end else begin
          acc_d[i] = sum[i][ACC_W-1:0];
        end
      end
    end
  end

  // Accumulators and registered enables.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cen_q <= '0;
    end else begin
      acc_q <= acc_d;
      cen_q <= cen_d;
    end
  end

  // Channel configuration; num > den is stored verbatim and clamped at use.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        num_q[i] <= ACC_W'(DEF_NUM);
        den_q[i] <= ACC_W'(DEF_DEN);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_sel[i]) begin
          num_q[i] <= bus.cfg_num;
          den_q[i] <= bus.cfg_den;
        end
      end
    end
  end

  // Error flag: one-cycle pulse after a write that was ignored or will be clamped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_wr && (!ch_ok || (bus.cfg_num > bus.cfg_den));
    end
  end

  assign bus.cen     = cen_q;
  assign bus.cfg_err = cfg_err_q;
endmodule
